// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM for a small multicycle processor. Each instruction walks
// FETCH -> DECODE -> EXEC and then, depending on its opcode, optionally
// MEM and/or WB before returning to FETCH. An all-ones instruction halts
// the machine until Start is pulsed again.
//
// Parameters
//   IW     instruction width
//   OPW    opcode field width
//   OPLSB  opcode field LSB (OPLSB+OPW must not exceed IW)
//   CW     counter width
//   OP_STR / OP_LOD / OP_BEQ / OP_BNE  opcode encodings
//
// Ports
//   Clk          clock
//   Reset        asynchronous active-high reset
//   Start        begin (from IDLE) or resume (from HALT) execution
//   Instruction  machine code from instruction ROM, captured in FETCH
//   Zero         ALU zero flag, used combinationally for branches
//   MemDone      data memory completion, only observed in MEM
//   FetchEn      IR capture / PC advance strobe
//   BranchEn     take branch
//   RegWrEn      register file write
//   MemWrEn      memory write request
//   MemRdEn      memory read request
//   LoadInst     register file write source is memory
//   Ack          program done (held in HALT)
//   CycleCnt     cycles spent outside IDLE/HALT, saturating
//   InstCnt      retired instructions, saturating
module multicycle_ctrl #(
  parameter int             IW     = 9,
  parameter int             OPW    = 4,
  parameter int             OPLSB  = 4,
  parameter int             CW     = 16,
  parameter logic [OPW-1:0] OP_STR = 4'b0100,
  parameter logic [OPW-1:0] OP_LOD = 4'b0011,
  parameter logic [OPW-1:0] OP_BEQ = 4'b0101,
  parameter logic [OPW-1:0] OP_BNE = 4'b0110
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          Zero,
  input  logic          MemDone,
  output logic          FetchEn,
  output logic          BranchEn,
  output logic          RegWrEn,
  output logic          MemWrEn,
  output logic          MemRdEn,
  output logic          LoadInst,
  output logic          Ack,
  output logic [CW-1:0] CycleCnt,
  output logic [CW-1:0] InstCnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   ir_r;
  logic [OPW-1:0]  opc_s;
  logic            is_str_s;
  logic            is_lod_s;
  logic            is_beq_s;
  logic            is_bne_s;
  logic            is_branch_s;
  logic            ir_halt_s;
  logic            start_acc_s;
  logic            retire_s;
  logic            active_s;
  logic [CW-1:0]   cycle_cnt_r;
  logic [CW-1:0]   inst_cnt_r;

  assign opc_s       = ir_r[OPLSB+OPW-1:OPLSB];
  assign is_str_s    = (opc_s == OP_STR);
  assign is_lod_s    = (opc_s == OP_LOD);
  assign is_beq_s    = (opc_s == OP_BEQ);
  assign is_bne_s    = (opc_s == OP_BNE);
  assign is_branch_s = is_beq_s | is_bne_s;
  assign ir_halt_s   = &ir_r;

  // Start only counts in the two resting states; elsewhere it is ignored.
  assign start_acc_s = Start & ((state_r == S_IDLE) | (state_r == S_HALT));
  assign active_s    = (state_r != S_IDLE) & (state_r != S_HALT);

  // An instruction retires on the edge that returns the FSM to FETCH.
  assign retire_s = ((state_r == S_EXEC) & is_branch_s)
                  | ((state_r == S_MEM) & is_str_s & MemDone)
                  | (state_r == S_WB);

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction register, loaded only during FETCH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_r <= {IW{1'b0}};
    end else if (state_r == S_FETCH) begin
      ir_r <= Instruction;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next-state and control-output decode (outputs are a pure decode of the
  // state, except BranchEn which follows Zero within the EXEC cycle).
  always_comb begin
    state_nxt_s = state_r;
    FetchEn     = 1'b0;
    BranchEn    = 1'b0;
    RegWrEn     = 1'b0;
    MemWrEn     = 1'b0;
    MemRdEn     = 1'b0;
    LoadInst    = 1'b0;
    Ack         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        FetchEn     = 1'b1;
        state_nxt_s = S_DECODE;
      end
      S_DECODE: begin
        if (ir_halt_s) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch_s) begin
          BranchEn    = (is_beq_s & Zero) | (is_bne_s & ~Zero);
          state_nxt_s = S_FETCH;
        end else if (is_str_s | is_lod_s) begin
          state_nxt_s = S_MEM;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_MEM: begin
        MemWrEn = is_str_s;
        MemRdEn = is_lod_s;
        // No timeout: the request is held until memory answers.
        if (MemDone) begin
          if (is_lod_s) begin
            state_nxt_s = S_WB;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        RegWrEn     = 1'b1;
        LoadInst    = is_lod_s;
        state_nxt_s = S_FETCH;
      end
      S_HALT: begin
        Ack = 1'b1;
        if (Start) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Saturating activity and retirement counters, cleared when Start is taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_cnt_r <= CNT_ZERO;
      inst_cnt_r  <= CNT_ZERO;
    end else if (start_acc_s) begin
      cycle_cnt_r <= CNT_ZERO;
      inst_cnt_r  <= CNT_ZERO;
    end else begin
      if (active_s && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (retire_s && (inst_cnt_r != CNT_MAX)) begin
        inst_cnt_r <= inst_cnt_r + CNT_ONE;
      end else begin
        inst_cnt_r <= inst_cnt_r;
      end
    end
  end

  assign CycleCnt = cycle_cnt_r;
  assign InstCnt  = inst_cnt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Programs are described as lists of
// instructions; for each one the bench derives the expected per-cycle
// control timeline from the instruction class (ALU, branch, store, load,
// halt) and the memory wait it chose, and tracks expected counters.
module tb_multicycle_ctrl;

  localparam logic [3:0] OP_STR = 4'b0100;
  localparam logic [3:0] OP_LOD = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [8:0] HALT_INS = 9'h1FF;

  // Timeline roles: fetch, decode, execute, memory wait, memory done, writeback
  localparam int R_F  = 0;
  localparam int R_D  = 1;
  localparam int R_E  = 2;
  localparam int R_MW = 3;
  localparam int R_MD = 4;
  localparam int R_WB = 5;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [8:0]  Instruction = 9'd0;
  logic        Zero = 1'b0;
  logic        MemDone = 1'b0;
  logic        FetchEn, BranchEn, RegWrEn, MemWrEn, MemRdEn, LoadInst, Ack;
  logic [15:0] CycleCnt, InstCnt;

  int errors = 0;
  int checks = 0;
  int cyc_m  = 0;
  int inst_m = 0;
  bit halted_m = 1'b0;

  logic [8:0] prog_ins[$];
  int         prog_wt[$];
  int         prog_zm[$];

  multicycle_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .Zero(Zero), .MemDone(MemDone), .FetchEn(FetchEn), .BranchEn(BranchEn),
    .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn),
    .LoadInst(LoadInst), .Ack(Ack), .CycleCnt(CycleCnt), .InstCnt(InstCnt)
  );

  always #5 Clk = ~Clk;

  // {FetchEn, BranchEn, RegWrEn, MemWrEn, MemRdEn, LoadInst, Ack}
  function automatic logic [6:0] outs();
    return {FetchEn, BranchEn, RegWrEn, MemWrEn, MemRdEn, LoadInst, Ack};
  endfunction

  task automatic start_prog();
    logic [6:0] exp;
    @(negedge Clk);
    Start       = 1'b1;
    Instruction = 9'($urandom_range(0, 511));
    Zero        = 1'($urandom_range(0, 1));
    MemDone     = 1'($urandom_range(0, 1));
    #1;
    exp = halted_m ? 7'b0000001 : 7'b0000000;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL start_state got=%b want=%b", outs(), exp);
    end
    cyc_m    = 0;
    inst_m   = 0;
    halted_m = 1'b0;
  endtask

  // zm: 0 random Zero each cycle, 1 force Zero=0, 2 force Zero=1
  task automatic run_inst(input logic [8:0] ins, input int wt, input int zm);
    logic [3:0] op;
    bit st, ld, br, hl;
    int roles[$];
    logic [6:0] exp;
    logic z;
    op = ins[7:4];
    hl = (ins == HALT_INS);
    st = !hl && (op == OP_STR);
    ld = !hl && (op == OP_LOD);
    br = !hl && ((op == OP_BEQ) || (op == OP_BNE));
    roles = {};
    roles.push_back(R_F);
    roles.push_back(R_D);
    if (!hl) begin
      roles.push_back(R_E);
      if (st || ld) begin
        for (int m = 0; m < wt; m++) roles.push_back(R_MW);
        roles.push_back(R_MD);
      end
      if (!st && !br) roles.push_back(R_WB);
    end
    foreach (roles[k]) begin
      @(negedge Clk);
      if (zm == 1) z = 1'b0;
      else if (zm == 2) z = 1'b1;
      else z = 1'($urandom_range(0, 1));
      Zero  = z;
      Start = 1'($urandom_range(0, 1));
      if (roles[k] == R_MD) MemDone = 1'b1;
      else if (roles[k] == R_MW) MemDone = 1'b0;
      else MemDone = 1'($urandom_range(0, 1));
      Instruction = (roles[k] == R_F) ? ins : 9'($urandom_range(0, 511));
      #1;
      exp = 7'b0000000;
      case (roles[k])
        R_F:  exp[6] = 1'b1;
        R_E:  exp[5] = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
        R_MW, R_MD: begin exp[3] = st; exp[2] = ld; end
        R_WB: begin exp[4] = 1'b1; exp[1] = ld; end
        default: ;
      endcase
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL ctrl ins=%h step=%0d got=%b want=%b", ins, k, outs(), exp);
      end
      if (roles[k] == R_F) begin
        checks++;
        if (CycleCnt !== 16'(cyc_m) || InstCnt !== 16'(inst_m)) begin
          errors++;
          $display("FAIL counters_at_fetch ins=%h got cyc=%0d inst=%0d want cyc=%0d inst=%0d",
                   ins, CycleCnt, InstCnt, cyc_m, inst_m);
        end
      end
      if (cyc_m < 65535) cyc_m++;
      if (!hl && (k == roles.size() - 1) && inst_m < 65535) inst_m++;
    end
    if (hl) halted_m = 1'b1;
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Start       = 1'b0;
      Instruction = 9'($urandom_range(0, 511));
      Zero        = 1'($urandom_range(0, 1));
      MemDone     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (outs() !== 7'b0000001 || CycleCnt !== 16'(cyc_m) || InstCnt !== 16'(inst_m)) begin
        errors++;
        $display("FAIL halt_hold got=%b cyc=%0d inst=%0d want=0000001 cyc=%0d inst=%0d",
                 outs(), CycleCnt, InstCnt, cyc_m, inst_m);
      end
    end
  endtask

  task automatic run_prog();
    start_prog();
    foreach (prog_ins[i]) run_inst(prog_ins[i], prog_wt[i], prog_zm[i]);
    run_inst(HALT_INS, 0, 0);
    hold_halt(3);
    prog_ins = {};
    prog_wt  = {};
    prog_zm  = {};
  endtask

  task automatic idle_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Start       = 1'b0;
      Instruction = 9'($urandom_range(0, 511));
      Zero        = 1'($urandom_range(0, 1));
      MemDone     = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (outs() !== 7'b0000000 || CycleCnt !== 16'd0 || InstCnt !== 16'd0) begin
        errors++;
        $display("FAIL %s got=%b cyc=%0d inst=%0d want=0000000 cyc=0 inst=0",
                 tag, outs(), CycleCnt, InstCnt);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (outs() !== 7'b0000000 || CycleCnt !== 16'd0 || InstCnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got=%b cyc=%0d inst=%0d want all zero", outs(), CycleCnt, InstCnt);
    end
    @(negedge Clk);
    Reset = 1'b0;
    idle_quiet(4, "idle_after_reset");
  endtask

  task automatic test_alu();
    prog_ins.push_back(9'b000010001); prog_wt.push_back(0); prog_zm.push_back(0);
    run_prog();
  endtask

  task automatic test_load();
    prog_ins.push_back(9'b000110000); prog_wt.push_back(2); prog_zm.push_back(0);
    run_prog();
  endtask

  task automatic test_store();
    prog_ins.push_back(9'b001000000); prog_wt.push_back(0); prog_zm.push_back(0);
    prog_ins.push_back(9'b001001111); prog_wt.push_back(3); prog_zm.push_back(0);
    run_prog();
  endtask

  task automatic test_branch();
    prog_ins.push_back(9'b001010000); prog_wt.push_back(0); prog_zm.push_back(2);
    prog_ins.push_back(9'b001100000); prog_wt.push_back(0); prog_zm.push_back(2);
    prog_ins.push_back(9'b001010001); prog_wt.push_back(0); prog_zm.push_back(1);
    prog_ins.push_back(9'b101100010); prog_wt.push_back(0); prog_zm.push_back(1);
    run_prog();
  endtask

  task automatic test_back_to_back();
    logic [8:0] ins;
    for (int i = 0; i < 40; i++) begin
      ins = 9'($urandom_range(0, 511));
      if (i % 4 == 0) ins[7:4] = OP_LOD;
      if (i % 4 == 1) ins[7:4] = OP_STR;
      if (ins == HALT_INS) ins = 9'h0FF;
      prog_ins.push_back(ins);
      prog_wt.push_back($urandom_range(0, 3));
      prog_zm.push_back(0);
    end
    run_prog();
  endtask

  task automatic test_reset_mid_mem();
    start_prog();
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      Start       = 1'b0;
      MemDone     = 1'b0;
      Zero        = 1'($urandom_range(0, 1));
      Instruction = (k == 0) ? 9'b001000000 : 9'($urandom_range(0, 511));
    end
    #1;
    checks++;
    if (MemWrEn !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_req got=%b want=1", MemWrEn);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b0000000 || CycleCnt !== 16'd0 || InstCnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_mem got=%b cyc=%0d inst=%0d want all zero", outs(), CycleCnt, InstCnt);
    end
    @(negedge Clk);
    Reset    = 1'b0;
    halted_m = 1'b0;
    idle_quiet(5, "idle_after_mid_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid_mem();
    test_alu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
